// File: rtl/spram_access_arbiter_pkg.sv
// Shared grant encodings and parameter checks
// for the single-port RAM access arbiter.
package spram_access_arbiter_pkg;

  localparam int REQ_WR = 0;
  localparam int REQ_RD = 1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_WR   = 2'b01;
  localparam logic [1:0] GNT_RD   = 2'b10;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 6;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

endpackage

// File: rtl/spram_access_arbiter_rr_arb2.sv
// Two-requester arbiter, round-robin or write-first.
// req/gnt bit 0 = write, bit 1 = read; owns RR pointer.
module rr_arb2
  import spram_access_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       fixed_pri,
  input  logic       accept,
  output logic [1:0] gnt
);

  // 1 = read was granted last; reset so read wins first tie
  logic last_rd;

  always_comb begin
    gnt = GNT_NONE;
    unique case (1'b1)
      (req == 2'b11):
        gnt = (fixed_pri || last_rd) ? GNT_WR : GNT_RD;
      (req == GNT_WR):
        gnt = GNT_WR;
      (req == GNT_RD):
        gnt = GNT_RD;
      default:
        gnt = GNT_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd <= 1'b0;
    end else if (accept) begin
      last_rd <= gnt[REQ_RD];
    end
  end

endmodule

// File: rtl/spram_access_arbiter.sv
// Shares one single-port RAM between a writer and a reader.
// Ports: wr_*/rd_* requesters, ram_* registered command, busy.
module spram_access_arbiter
  import spram_access_arbiter_pkg::*;
#(
  parameter int P_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int P_ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int P_RD_LATENCY  = 2,
  parameter int P_WR_PRIORITY = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [P_ADDR_WIDTH-1:0] wr_addr,
  input  logic [P_DATA_WIDTH-1:0] wr_data,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [P_ADDR_WIDTH-1:0] rd_addr,
  output logic                    rd_rvalid,
  output logic [P_DATA_WIDTH-1:0] rd_rdata,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [P_ADDR_WIDTH-1:0] ram_addr,
  output logic [P_DATA_WIDTH-1:0] ram_din,
  input  logic [P_DATA_WIDTH-1:0] ram_dout,
  output logic                    busy
);

  if (!rd_lat_ok(P_RD_LATENCY)) begin : g_lat_chk
    $error("P_RD_LATENCY out of range 1..4");
  end

  logic [1:0] gnt;
  logic       accept;

  // read-valid bits: 1 cycle command + RAM latency
  logic [P_RD_LATENCY:0] rd_pipe;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({rd_valid, wr_valid}),
    .fixed_pri (P_WR_PRIORITY != 0),
    .accept    (accept),
    .gnt       (gnt)
  );

  // no grant is visible while reset is held
  assign wr_ready = rst_n & gnt[REQ_WR];
  assign rd_ready = rst_n & gnt[REQ_RD];
  assign accept   = wr_ready | rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rd_pipe  <= '0;
    end else begin
      ram_en  <= accept;
      ram_we  <= wr_ready;
      rd_pipe <= {rd_pipe[P_RD_LATENCY-1:0], rd_ready};
      if (accept) begin
        ram_addr <= wr_ready ? wr_addr : rd_addr;
      end
      if (wr_ready) begin
        ram_din <= wr_data;
      end
    end
  end

  assign rd_rvalid = rd_pipe[P_RD_LATENCY];
  assign rd_rdata  = ram_dout;
  assign busy      = ram_en | (|rd_pipe);

endmodule
